// File: rtl/win_check_controller.sv
// ---------------------------------------------------------------------------
// win_check_controller
//   Sequences the Connect-4 win-detection datapath after every move. Each
//   accepted start reloads the combo shifter (one LOAD cycle), then scans for
//   SEQ_LEN+PIPE_LAT cycles, leaving early when the recognizer reports a win.
//   The winner goes to game control through a busy/done handshake. game_over
//   is sticky until reset.
//
//   Optional feature macro: DRAW_DETECT_EN
//     When defined, a move counter saturates at CELLS. A no-win scan on a
//     full board reports a draw (winner=11) and ends the game.
//
// Ports
//   clock       in   1  system clock, posedge
//   resetn      in   1  asynchronous active-low reset
//   start       in   1  one-cycle request to check the board; taken only in IDLE
//   rec_out     in   2  recognizer result: 00 none, 01 red, 10 yellow, 11 none
//   rec_enable  out  1  shifter/recognizer enable: 0 reload/clear, 1 scan
//   busy        out  1  high from the cycle after an accepted start until done
//   done        out  1  one-cycle pulse when a check completes
//   winner      out  2  00 none, 01 red, 10 yellow, 11 draw
//   game_over   out  1  sticky, set once winner != 00
// ---------------------------------------------------------------------------
module win_check_controller #(
    parameter int unsigned SEQ_LEN  = 199,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned CELLS    = 42
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] rec_out,
    output logic       rec_enable,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       game_over
);

    localparam int unsigned      CNT_W     = $clog2(SEQ_LEN + PIPE_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SEQ_LEN + PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_VALID = CNT_W'(PIPE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        REPORT,
        OVER
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rec_enable_q, rec_enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       winner_q, winner_d;
    logic             game_over_q, game_over_d;

    logic             win_seen;
    logic             scan_last;

`ifdef DRAW_DETECT_EN
    localparam logic [5:0] MOVE_FULL = 6'(CELLS);
    logic [5:0] move_q, move_d;
`endif

    // Results in the first PIPE_LAT scan cycles still belong to the previous
    // scan, so they cannot end this one.
    assign win_seen  = (rec_out == 2'b01 || rec_out == 2'b10) && (cnt_q >= CNT_VALID);
    assign scan_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
`ifdef DRAW_DETECT_EN
        move_d      = move_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && !game_over_q) begin
                    state_d = LOAD;
`ifdef DRAW_DETECT_EN
                    if (move_q != MOVE_FULL) begin
                        move_d = move_q + 6'd1;
                    end
`endif
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (win_seen) begin
                    winner_d = rec_out;
                    state_d  = REPORT;
                end else if (scan_last) begin
                    state_d = REPORT;
`ifdef DRAW_DETECT_EN
                    if (move_q == MOVE_FULL) begin
                        winner_d = 2'b11;
                    end
`endif
                end
            end
            REPORT: begin
                if (winner_q != 2'b00) begin
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else begin
                    state_d = IDLE;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they line up with the
        // state they describe.
        rec_enable_d = (state_d == SCAN);
        busy_d       = (state_d == LOAD) || (state_d == SCAN);
        done_d       = (state_d == REPORT);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rec_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            winner_q     <= '0;
            game_over_q  <= 1'b0;
`ifdef DRAW_DETECT_EN
            move_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rec_enable_q <= rec_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            winner_q     <= winner_d;
            game_over_q  <= game_over_d;
`ifdef DRAW_DETECT_EN
            move_q       <= move_d;
`endif
        end
    end

    assign rec_enable = rec_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign winner     = winner_q;
    assign game_over  = game_over_q;

endmodule
